// File: rtl/neuron_grid_core.sv
// neuron_grid_core: sequential integrate-leak-fire engine for one TrueNorth-style core.
// Each tick walks every neuron across every axon; neuron/axon parameters come from the environment.
module neuron_grid_core #(
   parameter int NUM_NEURONS = 256,
   parameter int NUM_AXONS   = 256,
   parameter int PW          = 9,
   localparam int NW         = $clog2(NUM_NEURONS),
   localparam int AW         = $clog2(NUM_AXONS),
   localparam int PARAM_W    = NUM_AXONS + 9*PW + 31
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic [PARAM_W-1:0]   neuron_parameter,
   input  logic [1:0]           neuron_instruction,
   input  logic [NUM_AXONS-1:0] axon_spikes,
   output logic [NW-1:0]        neuron_num,
   output logic [AW-1:0]        axon_num,
   output logic                 scheduler_set,
   output logic                 scheduler_clr,
   output logic                 update_potential,
   output logic [PW-1:0]        potential_out,
   output logic                 spike_out,
   output logic                 done,
   output logic                 error
);

   typedef enum logic [2:0] {S_IDLE, S_SET, S_INTEG, S_FIRE, S_DONE} state_t;

   state_t        state_reg, state_next;
   logic [NW-1:0] neuron_reg, neuron_next;
   logic [AW-1:0] axon_reg, axon_next;
   logic [PW-1:0] acc_reg, acc_next;
   logic [PW-1:0] pot_reg, pot_next;
   logic          sched_set_reg, sched_set_next;
   logic          sched_clr_reg, sched_clr_next;
   logic          upd_reg, upd_next;
   logic          spike_reg, spike_next;
   logic          done_reg, done_next;
   logic          error_reg, error_next;

   // Clamp a PW+1 bit two's complement sum back into PW bits.
   function automatic logic [PW-1:0] sat(input logic [PW:0] x);
      if (x[PW] != x[PW-1])
         sat = {x[PW], {(PW-1){~x[PW]}}};
      else
         sat = x[PW-1:0];
   endfunction

   function automatic logic [PW:0] sext(input logic [PW-1:0] x);
      sext = {x[PW-1], x};
   endfunction

   // CSRAM row decode: synapse bit for axon j sits at the top of the row, MSB first.
   logic [NUM_AXONS-1:0] synapse;
   logic [PW-1:0]        weight_tab [4];
   logic [PW-1:0]        v_init, v_reset, leak, pos_thr, neg_thr;
   logic                 reset_mode;
   logic                 unused_routing;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_AXONS; gi++) begin : g_syn
         assign synapse[gi] = neuron_parameter[PARAM_W-1-gi];
      end
      for (gi = 0; gi < 4; gi++) begin : g_wt
         assign weight_tab[gi] = neuron_parameter[31 + (6-gi)*PW +: PW];
      end
   endgenerate

   assign v_init         = neuron_parameter[31 + 8*PW +: PW];
   assign v_reset        = neuron_parameter[31 + 7*PW +: PW];
   assign leak           = neuron_parameter[31 + 2*PW +: PW];
   assign pos_thr        = neuron_parameter[31 + 1*PW +: PW];
   assign neg_thr        = neuron_parameter[31 +: PW];
   assign reset_mode     = neuron_parameter[30];
   assign unused_routing = ^neuron_parameter[29:0];

   // Integration step plus the leak/threshold evaluation of the result.
   // The fire decision is made from the final integration value so the
   // outputs are already registered during the FIRE cycle.
   logic [PW-1:0] base, acc_new, v_leak, v_sub, fire_pot;
   logic          hit, fire, below;

   always_comb begin
      base     = (axon_reg == '0) ? v_init : acc_reg;
      hit      = axon_spikes[axon_reg] & synapse[axon_reg];
      acc_new  = hit ? sat(sext(base) + sext(weight_tab[neuron_instruction])) : base;
      v_leak   = sat(sext(acc_new) + sext(leak));
      v_sub    = sat(sext(v_leak) - sext(pos_thr));
      fire     = $signed(v_leak) >= $signed(pos_thr);
      below    = $signed(v_leak) < $signed(neg_thr);
      fire_pot = reset_mode ? v_sub : v_reset;
   end

   always_comb begin
      state_next     = state_reg;
      neuron_next    = neuron_reg;
      axon_next      = axon_reg;
      acc_next       = acc_reg;
      pot_next       = pot_reg;
      spike_next     = spike_reg;
      sched_set_next = 1'b0;
      sched_clr_next = 1'b0;
      upd_next       = 1'b0;
      done_next      = 1'b0;
      error_next     = error_reg | (tick && (state_reg != S_IDLE));

      case (state_reg)
         S_IDLE: begin
            if (tick) begin
               state_next     = S_SET;
               sched_set_next = 1'b1;
               neuron_next    = '0;
               axon_next      = '0;
            end
         end
         S_SET: begin
            state_next = S_INTEG;
         end
         S_INTEG: begin
            acc_next = acc_new;
            if (axon_reg == AW'(NUM_AXONS-1)) begin
               axon_next  = '0;
               state_next = S_FIRE;
               upd_next   = 1'b1;
               spike_next = fire;
               if (fire)
                  pot_next = fire_pot;
               else if (below)
                  pot_next = neg_thr;
               else
                  pot_next = v_leak;
            end else begin
               axon_next = axon_reg + 1'b1;
            end
         end
         S_FIRE: begin
            neuron_next = neuron_reg + 1'b1;
            if (neuron_reg == NW'(NUM_NEURONS-1)) begin
               state_next     = S_DONE;
               done_next      = 1'b1;
               sched_clr_next = 1'b1;
            end else begin
               state_next = S_INTEG;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_reg     <= S_IDLE;
         neuron_reg    <= '0;
         axon_reg      <= '0;
         acc_reg       <= '0;
         pot_reg       <= '0;
         spike_reg     <= 1'b0;
         sched_set_reg <= 1'b0;
         sched_clr_reg <= 1'b0;
         upd_reg       <= 1'b0;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         neuron_reg    <= neuron_next;
         axon_reg      <= axon_next;
         acc_reg       <= acc_next;
         pot_reg       <= pot_next;
         spike_reg     <= spike_next;
         sched_set_reg <= sched_set_next;
         sched_clr_reg <= sched_clr_next;
         upd_reg       <= upd_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
      end
   end

   assign neuron_num       = neuron_reg;
   assign axon_num         = axon_reg;
   assign scheduler_set    = sched_set_reg;
   assign scheduler_clr    = sched_clr_reg;
   assign update_potential = upd_reg;
   assign potential_out    = pot_reg;
   assign spike_out        = spike_reg;
   assign done             = done_reg;
   assign error            = error_reg;

endmodule

// File: tb/tb_neuron_grid_core.sv
// Directed bench for neuron_grid_core: CSRAM/axon-type model with potential writeback,
// neuron-0 runs aborted by reset, one full tick, and error/reset behaviour.
module tb_neuron_grid_core;

   logic         clk = 1'b0;
   logic         reset_n, tick;
   logic [367:0] neuron_parameter;
   logic [1:0]   neuron_instruction;
   logic [255:0] axon_spikes;
   logic [7:0]   neuron_num, axon_num;
   logic         scheduler_set, scheduler_clr, update_potential, spike_out, done, error;
   logic [8:0]   potential_out;

   logic [367:0] cfg [256];
   logic [1:0]   axon_type [256];
   logic [255:0] wb_valid;
   logic [8:0]   wb_val [256];
   logic         wb_clear;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   neuron_grid_core dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .tick               (tick),
      .neuron_parameter   (neuron_parameter),
      .neuron_instruction (neuron_instruction),
      .axon_spikes        (axon_spikes),
      .neuron_num         (neuron_num),
      .axon_num           (axon_num),
      .scheduler_set      (scheduler_set),
      .scheduler_clr      (scheduler_clr),
      .update_potential   (update_potential),
      .potential_out      (potential_out),
      .spike_out          (spike_out),
      .done               (done),
      .error              (error)
   );

   // Environment: CSRAM row lookup, written-back potential overrides V.
   always_comb begin
      neuron_parameter = cfg[neuron_num];
      if (wb_valid[neuron_num])
         neuron_parameter[111:103] = wb_val[neuron_num];
      neuron_instruction = axon_type[axon_num];
   end

   always @(posedge clk) begin
      if (wb_clear)
         wb_valid <= '0;
      else if (update_potential) begin
         wb_valid[neuron_num] <= 1'b1;
         wb_val[neuron_num]   <= potential_out;
      end
   end

   task automatic check_value(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [367:0] mk(input logic [255:0] mask, input int v, input int vr,
                                       input int w0, input int w1, input int w2, input int w3,
                                       input int lk, input int pt, input int nt, input bit mode);
      logic [255:0] syn;
      for (int j = 0; j < 256; j++) syn[255-j] = mask[j];
      return {syn, 9'(v), 9'(vr), 9'(w0), 9'(w1), 9'(w2), 9'(w3),
              9'(lk), 9'(pt), 9'(nt), mode, 30'd0};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b1;
      wb_clear = 1'b1;
      tick     = 1'b0;
      @(negedge clk);
      reset_n  = 1'b0;
      wb_clear = 1'b0;
   endtask

   // Tick, then wait for neuron 0's update; optional tick injected mid-integration.
   task automatic run_n0(input string tag, input int exp_pot, input int exp_spk, input bit inject);
      int lat;
      bit seen;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      check_value({tag, "_set"}, int'(scheduler_set), 1);
      lat  = 0;
      seen = 1'b0;
      for (int c = 0; c < 600 && !seen; c++) begin
         @(negedge clk);
         lat++;
         tick = (inject && lat == 20) ? 1'b1 : 1'b0;
         if (lat == 1)
            check_value({tag, "_set_pulse"}, int'(scheduler_set), 0);
         if (update_potential)
            seen = 1'b1;
      end
      tick = 1'b0;
      check_value({tag, "_lat"}, lat, 257);
      check_value({tag, "_nnum"}, int'(neuron_num), 0);
      check_value({tag, "_pot"}, int'($signed(potential_out)), exp_pot);
      check_value({tag, "_spk"}, int'(spike_out), exp_spk);
      check_value({tag, "_err"}, int'(error), inject ? 1 : 0);
      $display("run %-8s lat=%0d pot=%0d spike=%0d error=%0d", tag, lat,
               $signed(potential_out), spike_out, error);
   endtask

   initial begin
      int cyc, nup;
      bit seen_done;

      reset_n     = 1'b1;
      wb_clear    = 1'b1;
      tick        = 1'b0;
      axon_spikes = '0;
      for (int i = 0; i < 256; i++) begin
         cfg[i]       = '0;
         axon_type[i] = 2'd0;
      end
      repeat (2) @(negedge clk);
      check_value("rst_nnum", int'(neuron_num), 0);
      check_value("rst_outs", int'({scheduler_set, scheduler_clr, update_potential,
                                   spike_out, done, error}), 0);
      reset_n  = 1'b0;
      wb_clear = 1'b0;
      repeat (3) @(negedge clk);
      check_value("idle_quiet", int'({scheduler_set, update_potential, done, axon_num}), 0);

      // Axons 0..3 spiking and connected; 4,5 spiking only, 7 connected only.
      axon_spikes = 256'h3F;
      cfg[0] = mk(256'h8F, 0, 0, 5, 0, 0, 0, -1, 20, -256, 1'b0);
      run_n0("below", 19, 0, 1'b0); do_reset();
      cfg[0] = mk(256'h8F, 0, 0, 5, 0, 0, 0, -1, 19, -256, 1'b0);
      run_n0("fire_m0", 0, 1, 1'b0); do_reset();
      cfg[0] = mk(256'h8F, 0, 0, 5, 0, 0, 0, -1, 19, -256, 1'b1);
      run_n0("fire_m1", 0, 1, 1'b0); do_reset();
      cfg[0] = mk(256'h8F, 0, 7, 5, 0, 0, 0, -1, 19, -256, 1'b0);
      run_n0("vreset7", 7, 1, 1'b0); do_reset();

      // Mixed axon types: 3 - 2 + 7 + 5 = 13.
      axon_type[0] = 2'd1; axon_type[1] = 2'd2; axon_type[2] = 2'd3; axon_type[3] = 2'd0;
      cfg[0] = mk(256'hF, 0, 0, 5, 3, -2, 7, 0, 100, -256, 1'b0);
      run_n0("types", 13, 0, 1'b0); do_reset();
      for (int i = 0; i < 4; i++) axon_type[i] = 2'd0;

      axon_spikes = 256'h7;
      cfg[0] = mk(256'h7, 250, 255, 100, 0, 0, 0, 0, 255, -256, 1'b0);
      run_n0("satpos", 255, 1, 1'b0); do_reset();
      cfg[0] = mk(256'h7, 250, 255, 100, 0, 0, 0, 0, 255, -256, 1'b1);
      run_n0("satpos_m1", 0, 1, 1'b0); do_reset();
      cfg[0] = mk(256'h7, -250, 0, -100, 0, 0, 0, 0, 255, -200, 1'b0);
      run_n0("satneg", -200, 0, 1'b0); do_reset();
      cfg[0] = mk(256'h0, -256, 0, 0, 0, 0, 0, -1, 255, -256, 1'b0);
      run_n0("leakmin", -256, 0, 1'b0); do_reset();
      cfg[0] = mk(256'h0, 250, 0, 0, 0, 0, 0, 5, -10, -256, 1'b1);
      run_n0("subsat", 255, 1, 1'b0); do_reset();

      // Only the last axon contributes.
      axon_spikes = '0;
      axon_spikes[255] = 1'b1;
      cfg[0] = mk({1'b1, 255'd0}, 0, 0, 9, 0, 0, 0, 0, 100, -256, 1'b0);
      run_n0("axon255", 9, 0, 1'b0); do_reset();

      // Tick during integration is ignored but flagged.
      axon_spikes = 256'h3F;
      cfg[0] = mk(256'h8F, 0, 0, 5, 0, 0, 0, -1, 20, -256, 1'b0);
      run_n0("err_tick", 19, 0, 1'b1); do_reset();
      check_value("err_cleared", int'(error), 0);

      // Reset mid-tick.
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      repeat (48) @(negedge clk);
      tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      check_value("mid_err", int'(error), 1);
      repeat (50) @(negedge clk);
      check_value("mid_axon", int'(axon_num), 98);
      reset_n = 1'b1;
      #1;
      check_value("mid_rst_axon", int'(axon_num), 0);
      check_value("mid_rst_err", int'(error), 0);
      check_value("mid_rst_outs", int'({neuron_num, scheduler_set, scheduler_clr,
                                       update_potential, spike_out, done, potential_out}), 0);
      $display("run midrst  axon=%0d error=%0d", axon_num, error);
      @(negedge clk); reset_n = 1'b0;
      run_n0("restart", 19, 0, 1'b0); do_reset();

      // Full tick: no synapses, leak +1, V(n) = n%64 - 32.
      for (int i = 0; i < 256; i++)
         cfg[i] = mk(256'h0, (i % 64) - 32, 0, 0, 0, 0, 0, 1, 255, -256, 1'b0);
      axon_spikes = '1;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      cyc       = 1;
      nup       = 0;
      seen_done = 1'b0;
      while (!seen_done && cyc < 70000) begin
         if (update_potential) begin
            check_value("ft_nnum", int'(neuron_num), nup);
            check_value("ft_pot", int'($signed(potential_out)), (nup % 64) - 32 + 1);
            nup++;
         end
         if (done) begin
            seen_done = 1'b1;
            check_value("ft_updates", nup, 256);
            check_value("ft_cycles", cyc, 65794);
            check_value("ft_clr", int'(scheduler_clr), 1);
            check_value("ft_wrap", int'(neuron_num), 0);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check_value("ft_done_seen", int'(seen_done), 1);
      $display("run fulltick updates=%0d cycles=%0d", nup, cyc);
      @(negedge clk);
      check_value("ft_done_pulse", int'({done, scheduler_clr}), 0);

      // Next tick reads the written-back potential: -32 + 1 + 1.
      run_n0("wb", -30, 0, 1'b0); do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
